bitorder_in: RTL and testbench
==============================

Name: bitorder_in

Overview:
- Receive-side dibit-to-byte assembler for the RMII datapath.
- Takes the 2-bit stream from the PHY-side receiver, which sends each byte LSB dibit first: [1:0], [3:2], [5:4], [7:6]. Reassembles these into whole bytes for the byte-wide frame logic downstream.
- Tracks frame boundaries from the input valid.
- Reports byte count, a frame-done strobe and a truncated-byte error.

Parameters:
- CNT_W, 11, width of the per-frame byte counter; counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock (50 MHz RMII domain); all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- axiiv  input  1  dibit valid; high for the whole frame, low between frames
- axiid  input  2  dibit data
- axiov  output  1  byte valid, one-cycle pulse per completed byte
- axiod  output  8  assembled byte; held stable between pulses
- frame_done  output  1  one-cycle pulse after the frame ends (axiiv falls)
- frame_err  output  1  one-cycle pulse, coincident with frame_done, if the frame ended mid-byte
- byte_count  output  CNT_W  bytes delivered in the current or last frame

Behaviour:
- Reset (rst_n low, async): state IDLE, dibit index 0, shift register 0.
- Reset values of outputs: axiov=0, axiod=8'h00, frame_done=0, frame_err=0, byte_count=0.
- All outputs are registered.
- States:
  - IDLE: first cycle with axiiv=1 stores axiid into bits [1:0], sets index=1, clears byte_count to 0 and goes to RECV.
  - RECV, axiiv=1: store axiid into bits [2*index+1 : 2*index], index increments mod 4.
  - RECV, axiiv=1 and index==3: next cycle axiov=1, axiod={axiid, stored[5:0]}, byte_count+1 (saturating).
  - RECV, axiiv=0: go to IDLE.
    - frame_done=1 in the following cycle.
    - frame_err=1 in that same cycle iff index!=0; the partial byte is discarded and no axiov is issued.
    - Index resets to 0.
- Latency: the byte built from dibits on cycles k..k+3 appears with axiov high on cycle k+4.
- Byte-pulse rate: axiov is high at most once every 4 cycles in steady state.
- Back-to-back frames, axiiv re-asserted in the cycle after the drop:
  - IDLE accepts it as dibit 0 of the new frame.
  - frame_done for the old frame and byte_count clear happen in that same cycle.
  - frame_done reflects the old frame; byte_count reads 0 the cycle after.
- byte_count is held after frame_done until the next frame starts; it saturates and never wraps.
- axiod is held between pulses and is not cleared on frame end.
- Reset mid-frame: all state clears immediately; no frame_done or frame_err; the next axiiv high is treated as a new frame start.
- axiid is don't-care when axiiv=0.

Test Plan:
- 4-dibit frame 2'b01, 2'b00, 2'b11, 2'b10 (axiiv 4 cycles) -> axiov pulse at cycle 5 with axiod=8'hB1, byte_count=1; frame_done at cycle 6; frame_err=0.
- 64-byte frame of incrementing bytes 8'h00..8'h3F sent LSB-dibit first -> 64 axiov pulses spaced 4 cycles, axiod matches each byte, final byte_count=64, single frame_done.
- 6-dibit frame (1.5 bytes) -> one axiov (first byte), frame_done with frame_err=1, byte_count=1, no second pulse.
- Two 8-dibit frames separated by exactly one idle cycle -> 4 bytes total, two frame_done pulses, byte_count=2 after each, no cross-frame dibit mixing.
- rst_n asserted after 5 dibits of a frame -> all outputs 0 immediately, no frame_done; next 4-dibit frame 8'hA5 decodes correctly with byte_count=1.
- CNT_W=3, 10-byte frame -> byte_count saturates at 7, all 10 axiov pulses still emitted.

Source files
------------

// File: rtl/bitorder_in_if.sv
// RMII receive dibit stream in, assembled bytes and frame status out.
// master drives the dibit stream; slave is the assembler.
interface bitorder_in_if #(parameter int CNT_W = 11);
  logic             axiiv;
  logic [1:0]       axiid;
  logic             axiov;
  logic [7:0]       axiod;
  logic             frame_done;
  logic             frame_err;
  logic [CNT_W-1:0] byte_count;

  modport master (output axiiv, axiid,
                  input  axiov, axiod, frame_done, frame_err, byte_count);
  modport slave  (input  axiiv, axiid,
                  output axiov, axiod, frame_done, frame_err, byte_count);
endinterface

// File: rtl/bitorder_in.sv
// Dibit-to-byte assembler: LSB dibit first, byte out 1 cycle after its 4th dibit.
// No backpressure; frame end (axiiv fall) yields frame_done, plus frame_err if mid-byte.
module bitorder_in #(
  parameter int CNT_W = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  bitorder_in_if.slave  bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0] state;
  logic [1:0] idx;
  logic [5:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= 2'd0;
      sh             <= 6'd0;
      bus.axiov      <= 1'b0;
      bus.axiod      <= 8'h00;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.byte_count <= '0;
    end else begin
      bus.axiov      <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.axiiv) begin
            sh[1:0]        <= bus.axiid;
            idx            <= 2'd1;
            bus.byte_count <= '0;
            state          <= RECV;
          end
        end
        default: begin
          if (bus.axiiv) begin
            idx <= idx + 2'd1;
            case (idx)
              2'd0: sh[1:0] <= bus.axiid;
              2'd1: sh[3:2] <= bus.axiid;
              2'd2: sh[5:4] <= bus.axiid;
              default: begin
                bus.axiov <= 1'b1;
                bus.axiod <= {bus.axiid, sh};
                // Saturate rather than wrap so oversize frames stay visibly oversize.
                if (bus.byte_count != CNT_MAX)
                  bus.byte_count <= bus.byte_count + 1'b1;
              end
            endcase
          end else begin
            // Any dibits of an unfinished byte are dropped here.
            state          <= IDLE;
            idx            <= 2'd0;
            bus.frame_done <= 1'b1;
            bus.frame_err  <= (idx != 2'd0);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bitorder_in.sv
// Scoreboard bench for bitorder_in; a CNT_W=3 copy shares the stimulus to cover saturation.
module tb_bitorder_in;
  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  bitorder_in_if #(.CNT_W(11)) bus ();
  bitorder_in_if #(.CNT_W(3))  bus_s ();
  assign bus_s.axiiv = bus.axiiv;
  assign bus_s.axiid = bus.axiid;

  bitorder_in #(.CNT_W(11)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  bitorder_in #(.CNT_W(3))  dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  typedef struct { logic [7:0] d; int cnt; int cnt_s; int cyc; } exp_byte_t;
  typedef struct { logic err; int cnt; int cnt_s; int cyc; } exp_frame_t;

  exp_byte_t  byte_q[$];
  exp_frame_t frame_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_bytes_seen = 0;
  int n_frames_seen = 0;

  // model state
  bit         m_in_frame = 0;
  int         m_idx = 0;
  logic [7:0] m_byte = 8'h00;
  int         m_cnt = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic drive_dibit(input logic [1:0] d);
    exp_byte_t e;
    @(posedge clk); #1;
    bus.axiiv = 1'b1;
    bus.axiid = d;
    if (!m_in_frame) begin
      m_in_frame = 1;
      m_idx = 0;
      m_cnt = 0;
    end
    m_byte[2*m_idx +: 2] = d;
    if (m_idx == 3) begin
      m_cnt++;
      e.d = m_byte; e.cnt = m_cnt; e.cnt_s = sat3(m_cnt); e.cyc = cyc + 1;
      byte_q.push_back(e);
    end
    m_idx = (m_idx + 1) % 4;
  endtask

  task automatic drive_idle();
    exp_frame_t f;
    @(posedge clk); #1;
    bus.axiiv = 1'b0;
    bus.axiid = 2'($urandom_range(0, 3));
    if (m_in_frame) begin
      f.err = (m_idx != 0); f.cnt = m_cnt; f.cnt_s = sat3(m_cnt); f.cyc = cyc + 1;
      frame_q.push_back(f);
    end
    m_in_frame = 0;
    m_idx = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) drive_dibit(b[2*i +: 2]);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_idle();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.axiov) begin
        n_bytes_seen++;
        if (byte_q.size() == 0) check("unexpected_byte", 1, 0);
        else begin
          exp_byte_t e;
          e = byte_q.pop_front();
          check("byte_data", 32'(bus.axiod), 32'(e.d));
          check("byte_cycle", cyc, e.cyc);
          check("byte_count", 32'(bus.byte_count), e.cnt);
          check("s_axiov", 32'(bus_s.axiov), 1);
          check("s_byte_data", 32'(bus_s.axiod), 32'(e.d));
          check("s_byte_count", 32'(bus_s.byte_count), e.cnt_s);
        end
      end
      if (bus.frame_done) begin
        n_frames_seen++;
        if (frame_q.size() == 0) check("unexpected_frame_done", 1, 0);
        else begin
          exp_frame_t f;
          f = frame_q.pop_front();
          check("frame_err", 32'(bus.frame_err), 32'(f.err));
          check("frame_cycle", cyc, f.cyc);
          check("frame_count", 32'(bus.byte_count), f.cnt);
          check("s_frame_done", 32'(bus_s.frame_done), 1);
          check("s_frame_count", 32'(bus_s.byte_count), f.cnt_s);
        end
      end
      if (bus.frame_err && !bus.frame_done) check("err_without_done", 1, 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;
    #35;
    check("rst_axiov", 32'(bus.axiov), 0);
    check("rst_axiod", 32'(bus.axiod), 0);
    check("rst_done", 32'(bus.frame_done), 0);
    check("rst_err", 32'(bus.frame_err), 0);
    check("rst_count", 32'(bus.byte_count), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle_cycles(2);

    // single byte 01,00,11,10 -> B1
    drive_dibit(2'b01); drive_dibit(2'b00); drive_dibit(2'b11); drive_dibit(2'b10);
    idle_cycles(3);

    // 64 incrementing bytes
    for (int b = 0; b < 64; b++) send_byte(8'(b));
    idle_cycles(3);

    // 1.5 bytes -> truncated
    send_byte(8'h5A);
    drive_dibit(2'b11); drive_dibit(2'b01);
    idle_cycles(3);

    // two 2-byte frames with a single idle cycle between them
    send_byte(8'h12); send_byte(8'h34);
    idle_cycles(1);
    send_byte(8'hDE); send_byte(8'hAD);
    idle_cycles(1);
    @(negedge clk);
    check("b2b_count_held", 32'(bus.byte_count), 2);
    idle_cycles(2);

    // reset after 5 dibits
    send_byte(8'hC3);
    drive_dibit(2'b10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.axiiv = 1'b0;
    m_in_frame = 0;
    m_idx = 0;
    #2;
    check("mid_rst_axiov", 32'(bus.axiov), 0);
    check("mid_rst_axiod", 32'(bus.axiod), 0);
    check("mid_rst_done", 32'(bus.frame_done), 0);
    check("mid_rst_err", 32'(bus.frame_err), 0);
    check("mid_rst_count", 32'(bus.byte_count), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle_cycles(2);
    send_byte(8'hA5);
    idle_cycles(3);

    // 10 bytes: CNT_W=3 copy saturates at 7
    for (int b = 0; b < 10; b++) send_byte(8'h10 + 8'(b));
    idle_cycles(4);

    @(negedge clk);
    check("axiod_held", 32'(bus.axiod), 32'h19);
    check("count_held", 32'(bus.byte_count), 10);
    check("s_count_sat", 32'(bus_s.byte_count), 7);
    check("bytes_pending", byte_q.size(), 0);
    check("frames_pending", frame_q.size(), 0);
    check("bytes_total", n_bytes_seen, 82);
    check("frames_total", n_frames_seen, 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
